// File: rtl/branch_pred.sv
// Direct-mapped branch predictor: 2-bit saturating counters with a target cache,
// combinational lookup, clocked update, one-cycle mispredict redirect and event counters.
module branch_pred #(
    parameter int unsigned ENTRIES  = 16,
    parameter int unsigned INST_LEN = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] if_pc,
    output logic        pred_taken,
    output logic [31:0] pred_npc,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_is_br,
    input  logic        upd_taken,
    input  logic [31:0] upd_dnpc,
    input  logic [31:0] upd_pred_npc,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic [31:0] br_cnt,
    output logic [31:0] miss_cnt
);

    localparam int unsigned IDX   = $clog2(ENTRIES);
    localparam int unsigned TAG_W = 32 - IDX - 2;

    logic             valid_q  [ENTRIES];
    logic [1:0]       ctr_q    [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [31:0]      target_q [ENTRIES];

    logic        redirect_valid_q;
    logic [31:0] redirect_pc_q;
    logic [31:0] br_cnt_q;
    logic [31:0] miss_cnt_q;

    // Lookup reads only registered table state, so same-cycle updates are not visible.
    logic [IDX-1:0] lk_idx;
    logic           lk_hit;

    assign lk_idx     = if_pc[IDX+1:2];
    assign lk_hit     = valid_q[lk_idx] && (tag_q[lk_idx] == if_pc[31:IDX+2]);
    assign pred_taken = lk_hit & ctr_q[lk_idx][1];
    assign pred_npc   = pred_taken ? target_q[lk_idx] : if_pc + 32'(INST_LEN);

    logic [IDX-1:0] up_idx;
    logic           up_hit;
    logic           accept;
    logic           br_upd;
    logic           mispredict;
    logic [1:0]     ctr_nxt;

    // Updates arriving while a redirect is pending belong to the squashed wrong path.
    assign up_idx     = upd_pc[IDX+1:2];
    assign up_hit     = valid_q[up_idx] && (tag_q[up_idx] == upd_pc[31:IDX+2]);
    assign accept     = upd_valid & ~redirect_valid_q;
    assign br_upd     = accept & upd_is_br;
    assign mispredict = accept & (upd_pred_npc != upd_dnpc);

    always_comb begin
        ctr_nxt = ctr_q[up_idx];
        if (upd_taken && ctr_q[up_idx] != 2'd3) begin
            ctr_nxt = ctr_q[up_idx] + 2'd1;
        end else if (!upd_taken && ctr_q[up_idx] != 2'd0) begin
            ctr_nxt = ctr_q[up_idx] - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= 2'd1;
            end
        end else if (br_upd) begin
            if (up_hit) begin
                ctr_q[up_idx] <= ctr_nxt;
            end else if (upd_taken) begin
                valid_q[up_idx] <= 1'b1;
                ctr_q[up_idx]   <= 2'd2;
            end
        end
    end

    // On a hit the tag already matches, so rewriting it is harmless.
    always_ff @(posedge clk) begin
        if (br_upd && upd_taken) begin
            tag_q[up_idx]    <= upd_pc[31:IDX+2];
            target_q[up_idx] <= upd_dnpc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= 32'd0;
            br_cnt_q         <= 32'd0;
            miss_cnt_q       <= 32'd0;
        end else begin
            redirect_valid_q <= mispredict;
            if (mispredict) begin
                redirect_pc_q <= upd_dnpc;
                miss_cnt_q    <= miss_cnt_q + 32'd1;
            end
            if (br_upd) begin
                br_cnt_q <= br_cnt_q + 32'd1;
            end
        end
    end

    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign br_cnt         = br_cnt_q;
    assign miss_cnt       = miss_cnt_q;

    logic unused_pc_bits;
    assign unused_pc_bits = ^{if_pc[1:0], upd_pc[1:0]};

endmodule
